embed_lookup_engine: RTL and testbench
======================================

EMBED_LOOKUP_ENGINE -- requirements
Module: embed_lookup_engine

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, signed width of one stored embedding element.
REQ-002 SHALL have parameter EMBED_DIM, default 8, elements per embedding vector.
REQ-003 SHALL have parameter DEPTH, default 1024, number of table rows; IDX_W = $clog2(DEPTH), min 1.
REQ-004 SHALL have parameter ACC_WIDTH, default 16, signed width of each output element (ACC_WIDTH >= DATA_WIDTH).
REQ-005 SHALL have parameter INIT_FILE, default "", hex file loaded into the table at elaboration when non-empty.
REQ-006 clk  input  1  sole clock, rising edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 idx_valid  input  1  lookup request valid.
REQ-009 idx_ready  output  1  engine accepts request this cycle.
REQ-010 idx  input  IDX_W  row index.
REQ-011 idx_last  input  1  last index of a bag (pool mode).
REQ-012 mode  input  1  0 = single lookup, 1 = sum-pool bag; sampled on the first element of each bag.
REQ-013 out_valid  output  1  result valid.
REQ-014 out_ready  input  1  downstream accepts result.
REQ-015 data_out  output  EMBED_DIM*ACC_WIDTH  result vector, element k at [k*ACC_WIDTH +: ACC_WIDTH].
REQ-016 out_err  output  1  result involved at least one out-of-range index.
REQ-017 lookup_cnt  output  32  accepted-index counter, wraps at 2^32.

Function
REQ-018 Transfers SHALL occur only on valid&&ready; pipeline advance en = !out_valid || out_ready; idx_ready = en (and !wr_en when EMBED_WRITE_EN).
REQ-019 Table read SHALL be synchronous, one cycle; result registered; request accepted at cycle T appears on data_out with out_valid at T+2 when it completes a result.
REQ-020 While out_valid && !out_ready, data_out, out_err and internal stages SHALL hold unchanged; no result dropped or duplicated.
REQ-021 Single mode: each accepted index SHALL produce one result, elements sign-extended DATA_WIDTH to ACC_WIDTH; idx_last ignored.
REQ-022 Pool mode SHALL use states IDLE and ACCUM: IDLE->ACCUM on accepted first element with idx_last=0; ACCUM->IDLE on accepted element with idx_last=1; a first element with idx_last=1 yields a one-element bag.
REQ-023 Pool result SHALL be per-element signed sum of all bag rows, saturating to ACC_WIDTH signed min/max; saturation sticky within the bag.
REQ-024 Changes of mode while in ACCUM SHALL be ignored until the bag closes.
REQ-025 idx >= DEPTH SHALL contribute a zero vector and set out_err on its result (bag result if pooled).
REQ-026 lookup_cnt SHALL increment by one per accepted index, both modes.

Reset
REQ-027 On rst_n low: out_valid=0, data_out=0, out_err=0, lookup_cnt=0, state=IDLE, accumulator=0; idx_ready=0 while reset asserted.
REQ-028 Reset mid-bag SHALL discard the partial bag; table contents SHALL be unaffected.

Configuration
REQ-029 Macro EMBED_WRITE_EN defined: ports wr_en(1), wr_addr(IDX_W), wr_data(EMBED_DIM*DATA_WIDTH) present; write on clk when wr_en and wr_addr < DEPTH; idx_ready=0 during wr_en; lookup accepted the cycle after a write returns new data.
REQ-030 Macro undefined: no write ports; table is read-only ROM from INIT_FILE.

Structure
REQ-031 Package embed_pkg SHALL hold state enum (IDLE, ACCUM), mode constants, and saturate-add function.
REQ-032 Table storage SHALL be sub-module embed_ram (sync read, optional write port).

Verification
REQ-033 Single mode, row 5 = {1..8}, idx=5 accepted at T, out_ready=1 -> out_valid at T+2, elements 1..8 sign-extended, out_err=0.
REQ-034 Pool bag idx 3,7,9(last) rows all 0x01 -> one result, all elements 3, two cycles after last accepted.
REQ-035 Pool, DATA_WIDTH=8, ACC_WIDTH=8, ten rows of 0x7F -> elements saturate to 127; ten rows 0x80 -> -128.
REQ-036 out_ready=0 for 5 cycles with requests streaming -> idx_ready drops, data_out stable, all results later delivered in order.
REQ-037 idx=DEPTH -> zero vector, out_err=1; rst_n low mid-bag -> outputs zero, next bag sums from zero.
REQ-038 EMBED_WRITE_EN: write row 2 = all 0x11, lookup idx=2 next cycle -> elements 0x11; idx_ready=0 during write.

Source files
------------

// File: rtl/embed_pkg.sv
// Shared types, mode encodings and saturating arithmetic for the embedding lookup engine.
package embed_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

  localparam logic MODE_SINGLE = 1'b0;
  localparam logic MODE_POOL   = 1'b1;

  // Working width for sat_add; callers sign-extend into it and truncate back.
  localparam int SAT_W = 64;

  // Signed add of a and b, clamped to the range of a w-bit signed value (w < SAT_W).
  function automatic logic signed [SAT_W-1:0] sat_add(input logic signed [SAT_W-1:0] a,
                                                      input logic signed [SAT_W-1:0] b,
                                                      input int                      w);
    logic signed [SAT_W:0] sum;
    logic signed [SAT_W:0] hi;
    logic signed [SAT_W:0] lo;
    sum = {a[SAT_W-1], a} + {b[SAT_W-1], b};
    hi  = ((SAT_W+1)'(1) <<< (w - 1)) - (SAT_W+1)'(1);
    lo  = -((SAT_W+1)'(1) <<< (w - 1));
    if (sum > hi)      sat_add = hi[SAT_W-1:0];
    else if (sum < lo) sat_add = lo[SAT_W-1:0];
    else               sat_add = sum[SAT_W-1:0];
  endfunction

endpackage

// File: rtl/embed_ram.sv
// Embedding table: one row of EMBED_DIM elements per address, synchronous read.
// Optional write port when EMBED_WRITE_EN is defined; otherwise a read-only table.
module embed_ram #(
  parameter int  DATA_WIDTH = 8,
  parameter int  EMBED_DIM  = 8,
  parameter int  DEPTH      = 1024,
  parameter      INIT_FILE  = "",
  localparam int IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int ROW_W      = EMBED_DIM * DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_addr,
  output logic [ROW_W-1:0] rd_data
`ifdef EMBED_WRITE_EN
  ,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [ROW_W-1:0] wr_data
`endif
);

  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  logic [ROW_W-1:0] mem [DEPTH];

  // Addresses past the table end read as zero so the row register never holds stale data.
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= (32'(rd_addr) < DEPTH_U) ? mem[rd_addr] : '0;
  end

`ifdef EMBED_WRITE_EN
  always_ff @(posedge clk) begin
    if (wr_en && (32'(wr_addr) < DEPTH_U)) mem[wr_addr] <= wr_data;
  end
`endif

endmodule

// File: rtl/embed_lookup_engine.sv
// Embedding lookup with single-row and saturating sum-pool modes, two-cycle latency.
// Define EMBED_WRITE_EN to add a table write port that blocks lookups while writing.
module embed_lookup_engine
  import embed_pkg::*;
#(
  parameter int  DATA_WIDTH = 8,
  parameter int  EMBED_DIM  = 8,
  parameter int  DEPTH      = 1024,
  parameter int  ACC_WIDTH  = 16,
  parameter      INIT_FILE  = "",
  localparam int IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           idx_valid,
  output logic                           idx_ready,
  input  logic [IDX_W-1:0]               idx,
  input  logic                           idx_last,
  input  logic                           mode,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [EMBED_DIM*ACC_WIDTH-1:0] data_out,
  output logic                           out_err,
  output logic [31:0]                    lookup_cnt
`ifdef EMBED_WRITE_EN
  ,
  input  logic                           wr_en,
  input  logic [IDX_W-1:0]               wr_addr,
  input  logic [EMBED_DIM*DATA_WIDTH-1:0] wr_data
`endif
);

  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  logic   en, accept, start_p0, done_p0, oor_p0;
  state_e state, state_nx;
  logic   vld_p1, start_p1, done_p1, oor_p1;
  logic [EMBED_DIM*DATA_WIDTH-1:0] row_p1;
  logic signed [ACC_WIDTH-1:0] acc_p2 [EMBED_DIM];
  logic signed [ACC_WIDTH-1:0] acc_nx [EMBED_DIM];
  logic [EMBED_DIM-1:0] sat_p2, sat_nx;
  logic err_p2, err_nx;

  // Whole pipeline advances together; a stalled output freezes every stage.
  assign en = !out_valid || out_ready;
`ifdef EMBED_WRITE_EN
  assign idx_ready = rst_n && en && !wr_en;
`else
  assign idx_ready = rst_n && en;
`endif
  assign accept = idx_valid && idx_ready;
  assign oor_p0 = 32'(idx) >= DEPTH_U;

  // ---- Stage p0: accept request, bag framing ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    start_p0 = 1'b0;
    done_p0  = 1'b0;
    unique case (state)
      IDLE: begin
        start_p0 = 1'b1;
        if (mode == MODE_POOL) begin
          done_p0 = idx_last;
          if (accept && !idx_last) state_nx = ACCUM;
        end else begin
          done_p0 = 1'b1;
        end
      end
      ACCUM: begin
        // Mode is locked to pool until the bag closes.
        done_p0 = idx_last;
        if (accept && idx_last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lookup_cnt <= '0;
    else if (accept) lookup_cnt <= lookup_cnt + 32'd1;
  end

  embed_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .EMBED_DIM (EMBED_DIM),
    .DEPTH     (DEPTH),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk    (clk),
    .rd_en  (en),
    .rd_addr(idx),
    .rd_data(row_p1)
`ifdef EMBED_WRITE_EN
    ,
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data)
`endif
  );

  // ---- Stage p1: row read out of the table ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      start_p1 <= 1'b0;
      done_p1  <= 1'b0;
      oor_p1   <= 1'b0;
    end else if (en) begin
      vld_p1   <= accept;
      start_p1 <= start_p0;
      done_p1  <= done_p0;
      oor_p1   <= oor_p0;
    end
  end

  // Per-element saturating accumulate; once an element clips it stays clipped for the bag.
  always_comb begin
    logic signed [DATA_WIDTH-1:0] elem;
    logic signed [ACC_WIDTH-1:0]  base;
    logic signed [SAT_W-1:0]      sum;
    logic signed [SAT_W-1:0]      full;
    logic                         sticky;
    elem   = '0;
    base   = '0;
    sum    = '0;
    full   = '0;
    sticky = 1'b0;
    sat_nx = '0;
    err_nx = oor_p1 || (!start_p1 && err_p2);
    for (int k = 0; k < EMBED_DIM; k++) begin
      elem      = oor_p1 ? '0 : row_p1[k*DATA_WIDTH +: DATA_WIDTH];
      base      = start_p1 ? '0 : acc_p2[k];
      sticky    = !start_p1 && sat_p2[k];
      sum       = sat_add(SAT_W'(base), SAT_W'(elem), ACC_WIDTH);
      full      = SAT_W'(base) + SAT_W'(elem);
      acc_nx[k] = sticky ? base : ACC_WIDTH'(sum);
      sat_nx[k] = sticky || (sum != full);
    end
  end

  // ---- Stage p2: accumulator and registered result ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_err   <= 1'b0;
      data_out  <= '0;
      err_p2    <= 1'b0;
      sat_p2    <= '0;
      for (int k = 0; k < EMBED_DIM; k++) acc_p2[k] <= '0;
    end else if (en) begin
      out_valid <= vld_p1 && done_p1;
      if (vld_p1) begin
        err_p2 <= err_nx;
        sat_p2 <= sat_nx;
        for (int k = 0; k < EMBED_DIM; k++) acc_p2[k] <= acc_nx[k];
        if (done_p1) begin
          out_err <= err_nx;
          for (int k = 0; k < EMBED_DIM; k++) data_out[k*ACC_WIDTH +: ACC_WIDTH] <= acc_nx[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_embed_lookup_engine.sv
// Self-checking bench for embed_lookup_engine: bag-level reference model plus directed literal checks.
module tb_embed_lookup_engine;

  localparam int DW    = 8;
  localparam int ED    = 8;
  localparam int DEPTH = 20;
  localparam int AW    = 10;
  localparam int IW    = 5;
  localparam int VW    = ED * AW;
  localparam int ACC_MAX = 511;
  localparam int ACC_MIN = -512;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          idx_valid;
  logic          idx_ready;
  logic [IW-1:0] idx;
  logic          idx_last;
  logic          mode;
  logic          out_valid;
  logic          out_ready;
  logic [VW-1:0] data_out;
  logic          out_err;
  logic [31:0]   lookup_cnt;
`ifdef EMBED_WRITE_EN
  logic           wr_en;
  logic [IW-1:0]  wr_addr;
  logic [ED*DW-1:0] wr_data;
`endif

  embed_lookup_engine #(
    .DATA_WIDTH(DW), .EMBED_DIM(ED), .DEPTH(DEPTH), .ACC_WIDTH(AW), .INIT_FILE("")
  ) dut (
    .clk(clk), .rst_n(rst_n), .idx_valid(idx_valid), .idx_ready(idx_ready),
    .idx(idx), .idx_last(idx_last), .mode(mode), .out_valid(out_valid),
    .out_ready(out_ready), .data_out(data_out), .out_err(out_err),
    .lookup_cnt(lookup_cnt)
`ifdef EMBED_WRITE_EN
    , .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct { logic [VW-1:0] data; logic err; } exp_t;
  exp_t q[$];

  logic signed [DW-1:0] tbl [DEPTH][ED];

  // Model state: the bag currently being collected
  bit m_in_bag;
  bit m_pool;
  bit m_err;
  int m_sum [ED];
  bit m_sat [ED];
  int m_cnt;

  task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic model_accept(input int i, input bit last, input bit m);
    exp_t e;
    int v;
    m_cnt++;
    if (!m_in_bag) begin
      m_pool = m;
      m_err  = 1'b0;
      for (int k = 0; k < ED; k++) begin m_sum[k] = 0; m_sat[k] = 1'b0; end
    end
    if (i >= DEPTH) m_err = 1'b1;
    for (int k = 0; k < ED; k++) begin
      v = (i < DEPTH) ? int'(tbl[i][k]) : 0;
      if (!m_sat[k]) begin
        m_sum[k] = m_sum[k] + v;
        if (m_sum[k] > ACC_MAX) begin m_sum[k] = ACC_MAX; m_sat[k] = 1'b1; end
        else if (m_sum[k] < ACC_MIN) begin m_sum[k] = ACC_MIN; m_sat[k] = 1'b1; end
      end
    end
    if (!m_pool || last) begin
      for (int k = 0; k < ED; k++) e.data[k*AW +: AW] = AW'(m_sum[k]);
      e.err = m_err;
      q.push_back(e);
      m_in_bag = 1'b0;
    end else begin
      m_in_bag = 1'b1;
    end
  endtask

  // Compare process: every falling edge, check outputs, then feed the upcoming accept to the model.
  bit            stall_prev = 1'b0;
  logic [VW-1:0] prev_data;
  logic          prev_err;
  bit            exp_ready;
  exp_t          e_front;
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_in_bag   = 1'b0;
      m_cnt      = 0;
      stall_prev = 1'b0;
    end else begin
      chk("lookup_cnt", VW'(lookup_cnt), VW'(m_cnt));
`ifdef EMBED_WRITE_EN
      exp_ready = (!out_valid || out_ready) && !wr_en;
`else
      exp_ready = !out_valid || out_ready;
`endif
      chk("idx_ready", VW'(idx_ready), VW'(exp_ready));
      if (stall_prev) begin
        chk("hold_valid", VW'(out_valid), VW'(1));
        chk("hold_data", data_out, prev_data);
        chk("hold_err", VW'(out_err), VW'(prev_err));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_result: got %0h expected no result", data_out);
        end else begin
          e_front = q.pop_front();
          chk("result_data", data_out, e_front.data);
          chk("result_err", VW'(out_err), VW'(e_front.err));
        end
      end
      stall_prev = out_valid && !out_ready;
      prev_data  = data_out;
      prev_err   = out_err;
      if (idx_valid && idx_ready) model_accept(int'(idx), idx_last, mode);
    end
  end

  task automatic send(input int i, input bit last, input bit m);
    bit ok;
    logic [31:0] iv;
    ok = 1'b0;
    iv = 32'(i);
    idx_valid = 1'b1; idx = iv[IW-1:0]; idx_last = last; mode = m;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      ok = idx_ready;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send_timeout: got idx_ready=0 expected 1 for idx %0d", i);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    idx_valid = 1'b0; idx_last = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int n = 0; n < 40 && !done; n++) begin
      @(posedge clk); #1;
      done = (q.size() == 0) && !out_valid;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
  endtask

  task automatic load_row(input int i);
    logic [ED*DW-1:0] r;
    for (int k = 0; k < ED; k++) r[k*DW +: DW] = tbl[i][k];
`ifdef EMBED_WRITE_EN
    wr_en = 1'b1; wr_addr = IW'(i); wr_data = r;
    @(posedge clk); #1;
    wr_en = 1'b0;
`else
    dut.u_ram.mem[i] = r;
`endif
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; idx_valid = 1'b0; idx = '0; idx_last = 1'b0; mode = 1'b0; out_ready = 1'b1;
`ifdef EMBED_WRITE_EN
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
`endif
    for (int i = 0; i < DEPTH; i++)
      for (int k = 0; k < ED; k++) tbl[i][k] = DW'(i * 13 + k * 5 + 3);
    for (int k = 0; k < ED; k++) begin
      tbl[0][k]  = DW'(-16 + k);
      tbl[5][k]  = DW'(k + 1);
      tbl[3][k]  = 8'h01;
      tbl[7][k]  = 8'h01;
      tbl[9][k]  = 8'h01;
      tbl[10][k] = 8'h7F;
      tbl[11][k] = 8'h80;
    end
    @(posedge clk); #1;
    for (int i = 0; i < DEPTH; i++) load_row(i);
    repeat (2) @(posedge clk); #1;

    chk("rst_out_valid", VW'(out_valid), VW'(0));
    chk("rst_data_out", data_out, VW'(0));
    chk("rst_out_err", VW'(out_err), VW'(0));
    chk("rst_lookup_cnt", VW'(lookup_cnt), VW'(0));
    chk("rst_idx_ready", VW'(idx_ready), VW'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single lookup of row 5: result two edges after acceptance
    send(5, 1'b0, 1'b0); idle();
    chk("single_lat_t1", VW'(out_valid), VW'(0));
    @(posedge clk); #1;
    chk("single_lat_t2", VW'(out_valid), VW'(1));
    chk("single_row5", data_out, {10'd8, 10'd7, 10'd6, 10'd5, 10'd4, 10'd3, 10'd2, 10'd1});
    chk("single_row5_err", VW'(out_err), VW'(0));
    drain();

    send(0, 1'b1, 1'b0); idle();
    @(posedge clk); #1;
    chk("single_sext", data_out,
        {10'h3F7, 10'h3F6, 10'h3F5, 10'h3F4, 10'h3F3, 10'h3F2, 10'h3F1, 10'h3F0});
    drain();

    // Pool bag 3,7,9
    send(3, 1'b0, 1'b1); send(7, 1'b0, 1'b1); send(9, 1'b1, 1'b1); idle();
    chk("pool_lat_t1", VW'(out_valid), VW'(0));
    @(posedge clk); #1;
    chk("pool_lat_t2", VW'(out_valid), VW'(1));
    chk("pool_sum3", data_out, {8{10'd3}});
    drain();

    // Saturation both ways
    for (int n = 0; n < 9; n++) send(10, 1'b0, 1'b1);
    send(10, 1'b1, 1'b1); idle();
    @(posedge clk); #1;
    chk("sat_pos", data_out, {8{10'h1FF}});
    drain();
    for (int n = 0; n < 9; n++) send(11, 1'b0, 1'b1);
    send(11, 1'b1, 1'b1); idle();
    @(posedge clk); #1;
    chk("sat_neg", data_out, {8{10'h200}});
    drain();

    // Out-of-range index, single and inside a bag
    send(DEPTH, 1'b0, 1'b0); idle();
    @(posedge clk); #1;
    chk("oor_zero", data_out, VW'(0));
    chk("oor_err", VW'(out_err), VW'(1));
    drain();
    send(5, 1'b0, 1'b1); send(25, 1'b1, 1'b1); idle();
    @(posedge clk); #1;
    chk("oor_bag_data", data_out, {10'd8, 10'd7, 10'd6, 10'd5, 10'd4, 10'd3, 10'd2, 10'd1});
    chk("oor_bag_err", VW'(out_err), VW'(1));
    drain();

    // Mode flips mid-bag are ignored
    send(3, 1'b0, 1'b1); send(7, 1'b0, 1'b0); send(9, 1'b1, 1'b0); idle();
    @(posedge clk); #1;
    chk("mode_lock", data_out, {8{10'd3}});
    chk("mode_lock_err", VW'(out_err), VW'(0));
    drain();

    // Back-to-back singles
    for (int i = 12; i < 18; i++) send(i, 1'b0, 1'b0);
    idle();
    drain();

    // Downstream stall while requests stream in
    fork
      begin
        for (int i = 0; i < 6; i++) send(i, 1'b0, 1'b0);
        idle();
      end
      begin
        out_ready = 1'b0;
        repeat (4) @(posedge clk); #1;
        chk("stall_idx_ready", VW'(idx_ready), VW'(0));
        chk("stall_out_valid", VW'(out_valid), VW'(1));
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset in the middle of a bag
    send(3, 1'b0, 1'b1); send(7, 1'b0, 1'b1); idle();
    rst_n = 1'b0; #1;
    chk("midrst_valid", VW'(out_valid), VW'(0));
    chk("midrst_data", data_out, VW'(0));
    chk("midrst_err", VW'(out_err), VW'(0));
    chk("midrst_cnt", VW'(lookup_cnt), VW'(0));
    chk("midrst_ready", VW'(idx_ready), VW'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(3, 1'b0, 1'b1); send(9, 1'b1, 1'b1); idle();
    @(posedge clk); #1;
    chk("postrst_sum", data_out, {8{10'd2}});
    drain();

`ifdef EMBED_WRITE_EN
    // Write row 2 then read it back the following cycle
    for (int k = 0; k < ED; k++) tbl[2][k] = 8'h11;
    wr_en = 1'b1; wr_addr = IW'(2); wr_data = {8{8'h11}};
    idx_valid = 1'b1; idx = IW'(2); idx_last = 1'b0; mode = 1'b0;
    @(negedge clk);
    chk("wr_blocks_ready", VW'(idx_ready), VW'(0));
    @(posedge clk); #1;
    wr_en = 1'b0;
    send(2, 1'b0, 1'b0); idle();
    @(posedge clk); #1;
    chk("wr_readback", data_out, {8{10'h011}});
    drain();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
